// File: rtl/gray2bin_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gray2bin_arb
// Purpose  : Round-robin shared two-stage Gray-to-binary converter with a
//            valid/ready result port. Define GRAY2BIN_ARB_FIXPRI_EN for
//            fixed (lowest-index-wins) priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module gray2bin_arb #(
    parameter int DWID = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*DWID-1:0] i_gray,
    output logic [NREQ-1:0]      o_gnt,
    output logic                 o_vld,
    output logic [IDW-1:0]       o_id,
    output logic [DWID-1:0]      o_bin,
    input  logic                 i_rdy
);

    logic            w_adv1;
    logic            w_adv2;
    logic            w_found;
    logic [IDW-1:0]  w_sel;
    logic [NREQ-1:0] w_onehot;
    logic [DWID-1:0] w_gray_sel;
    logic [DWID-1:0] w_bin;

    logic            r_s1_vld;
    logic [IDW-1:0]  r_s1_id;
    logic [DWID-1:0] r_s1_gray;

    assign w_adv2 = !o_vld || i_rdy;
    assign w_adv1 = !r_s1_vld || w_adv2;

`ifdef GRAY2BIN_ARB_FIXPRI_EN
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_onehot   = '0;
        w_gray_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found     = 1'b1;
                w_sel       = IDW'(i);
                w_onehot[i] = 1'b1;
                w_gray_sel  = i_gray[i*DWID +: DWID];
            end
        end
    end
`else
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    int             w_idx;

    // Search starts at the pointer and wraps modulo NREQ (NREQ need not be a power of two)
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_onehot   = '0;
        w_gray_sel = '0;
        w_idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found         = 1'b1;
                w_sel           = IDW'(w_idx);
                w_onehot[w_idx] = 1'b1;
                w_gray_sel      = i_gray[w_idx*DWID +: DWID];
            end
        end
    end

    assign w_ptr_nxt = (w_sel == IDW'(NREQ-1)) ? '0 : w_sel + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_adv1 && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // A grant is only issued when stage 1 can actually capture the word
    assign o_gnt = (rst || !w_adv1) ? '0 : w_onehot;

    generate
        for (genvar j = 0; j < DWID; j++) begin : g_conv
            assign w_bin[j] = ^r_s1_gray[DWID-1:j];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_id   <= '0;
            r_s1_gray <= '0;
            o_vld     <= 1'b0;
            o_id      <= '0;
            o_bin     <= '0;
        end else begin
            if (w_adv2) begin
                o_vld <= r_s1_vld;
                o_id  <= r_s1_id;
                o_bin <= w_bin;
            end
            if (w_adv1) begin
                r_s1_vld <= w_found;
                if (w_found) begin
                    r_s1_id   <= w_sel;
                    r_s1_gray <= w_gray_sel;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray2bin_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gray2bin_arb
// Purpose  : Scoreboard bench for gray2bin_arb (default 16-bit/4-requester
//            instance plus DWID=1 and DWID=32 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray2bin_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdy;
    logic [3:0]  req;
    logic [63:0] gray;
    logic [3:0]  gnt;
    logic        vld;
    logic [1:0]  id;
    logic [15:0] bin;

    logic [1:0]  s_req;
    logic [1:0]  s1_gray;
    logic [63:0] s32_gray;
    logic [1:0]  gnt1, gnt32;
    logic        vld1, vld32;
    logic        id1, id32;
    logic        bin1;
    logic [31:0] bin32;

    gray2bin_arb #(.DWID(16), .NREQ(4), .IDW(2)) u_dut (
        .clk(clk), .rst(rst), .i_req(req), .i_gray(gray), .o_gnt(gnt),
        .o_vld(vld), .o_id(id), .o_bin(bin), .i_rdy(rdy)
    );

    gray2bin_arb #(.DWID(1), .NREQ(2), .IDW(1)) u_w1 (
        .clk(clk), .rst(rst), .i_req(s_req), .i_gray(s1_gray), .o_gnt(gnt1),
        .o_vld(vld1), .o_id(id1), .o_bin(bin1), .i_rdy(rdy)
    );

    gray2bin_arb #(.DWID(32), .NREQ(2), .IDW(1)) u_w32 (
        .clk(clk), .rst(rst), .i_req(s_req), .i_gray(s32_gray), .o_gnt(gnt32),
        .o_vld(vld32), .o_id(id32), .o_bin(bin32), .i_rdy(rdy)
    );

    typedef struct {
        int          id;
        logic [31:0] bin;
    } exp_t;

    exp_t q_main[$];
    exp_t q_w1[$];
    exp_t q_w32[$];

    int errors = 0;
    int checks = 0;

`ifdef GRAY2BIN_ARB_FIXPRI_EN
    function automatic logic [3:0] pick(input logic [3:0] rr, input logic [3:0] fp);
        return fp;
    endfunction
`else
    function automatic logic [3:0] pick(input logic [3:0] rr, input logic [3:0] fp);
        return rr;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    // Reference: each binary bit is the XOR of its Gray bit with the binary bit above
    function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
        logic [31:0] b;
        b        = '0;
        b[w-1]   = g[w-1];
        for (int j = w - 2; j >= 0; j--) begin
            b[j] = b[j+1] ^ g[j];
        end
        return b;
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] eg, input string nm);
        int k;
        req = r;
        @(negedge clk);
        chk(nm, 32'(gnt), 32'(eg));
        if (eg != 4'b0000) begin
            k = idx_of(eg);
            q_main.push_back('{k, g2b(32'(gray[k*16 +: 16]), 16)});
        end
        @(posedge clk); #1;
    endtask

    // Single-requester latency test with a hand-computed binary value
    task automatic lat(input logic [15:0] g, input logic [15:0] b);
        gray[15:0] = g;
        req        = 4'b0001;
        @(negedge clk);
        chk("lat_gnt", 32'(gnt), 32'h1);
        q_main.push_back('{0, 32'(b)});
        @(posedge clk); #1;
        req = 4'b0000;
        @(posedge clk); #1;
        chk("lat_vld", 32'(vld), 32'h1);
        chk("lat_id", 32'(id), 32'h0);
        chk("lat_bin", 32'(bin), 32'(b));
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (vld && rdy) begin
            if (q_main.size() == 0) begin
                errors++; checks++;
                $display("FAIL main_unexpected: got id %0d bin 0x%0h, required no result", id, bin);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                chk("main_id", 32'(id), 32'(e.id));
                chk("main_bin", 32'(bin), e.bin);
            end
        end
        if (vld1 && rdy) begin
            if (q_w1.size() == 0) begin
                errors++; checks++;
                $display("FAIL w1_unexpected: got id %0d bin %0d, required no result", id1, bin1);
            end else begin
                exp_t e;
                e = q_w1.pop_front();
                chk("w1_id", 32'(id1), 32'(e.id));
                chk("w1_bin", 32'(bin1), e.bin);
            end
        end
        if (vld32 && rdy) begin
            if (q_w32.size() == 0) begin
                errors++; checks++;
                $display("FAIL w32_unexpected: got id %0d bin 0x%0h, required no result", id32, bin32);
            end else begin
                exp_t e;
                e = q_w32.pop_front();
                chk("w32_id", 32'(id32), 32'(e.id));
                chk("w32_bin", bin32, e.bin);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst      = 1'b1;
        rdy      = 1'b1;
        req      = 4'b0000;
        gray     = {16'h1234, 16'h00FF, 16'hA5A5, 16'h0001};
        s_req    = 2'b00;
        s1_gray  = 2'b00;
        s32_gray = '0;

        // Reset state, with requests pending
        repeat (3) @(posedge clk);
        #1;
        req = 4'b1111;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_id", 32'(id), 32'h0);
        chk("rst_bin", 32'(bin), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All four requesting continuously
        step(4'b1111, 4'b0001, "rr_gnt0");
        step(4'b1111, pick(4'b0010, 4'b0001), "rr_gnt1");
        step(4'b1111, pick(4'b0100, 4'b0001), "rr_gnt2");
        step(4'b1111, pick(4'b1000, 4'b0001), "rr_gnt3");
        step(4'b1111, 4'b0001, "rr_gnt4");
        repeat (3) step(4'b0000, 4'b0000, "drain_gnt");

        // Latency and conversion with hand values
        lat(16'h8000, 16'hFFFF);
        lat(16'h0003, 16'h0002);
        lat(16'hC000, 16'h8000);

        // Requesters 1 and 3 after pointer moves to 2
        step(4'b0010, 4'b0010, "wrap_pre");
        step(4'b1010, pick(4'b1000, 4'b0010), "wrap_gnt3");
        step(4'b1010, 4'b0010, "wrap_gnt1");
        step(4'b1010, pick(4'b1000, 4'b0010), "wrap_gnt3b");
        repeat (3) step(4'b0000, 4'b0000, "drain_gnt");

        // Stall: fill both stages, hold 5 cycles, then release
        rdy = 1'b0;
        step(4'b1111, 4'b0001, "stall_fill0");
        step(4'b1111, pick(4'b0010, 4'b0001), "stall_fill1");
        for (int i = 0; i < 3; i++) begin
            chk("stall_vld", 32'(vld), 32'h1);
            chk("stall_id", 32'(id), 32'h0);
            chk("stall_bin", 32'(bin), g2b(32'(gray[15:0]), 16));
            step(4'b1111, 4'b0000, "stall_gnt");
        end
        rdy = 1'b1;
        step(4'b1111, pick(4'b0100, 4'b0001), "resume_gnt");
        repeat (4) step(4'b0000, 4'b0000, "drain_gnt");

        // Reset with both stages valid
        step(4'b1111, pick(4'b1000, 4'b0001), "mrst_fill0");
        step(4'b1111, 4'b0001, "mrst_fill1");
        rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_gnt", 32'(gnt), 32'h0);
        q_main.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        chk("mrst_vld", 32'(vld), 32'h0);
        chk("mrst_id", 32'(id), 32'h0);
        chk("mrst_bin", 32'(bin), 32'h0);
        step(4'b1111, 4'b0001, "mrst_gnt_after");
        repeat (4) step(4'b0000, 4'b0000, "drain_gnt");

        // Width sweep: DWID=1 and DWID=32, alternating requesters
        for (int n = 0; n < 24; n++) begin
            k = n % 2;
            s_req = 2'(1 << k);
            s1_gray[k] = 1'($urandom);
            s32_gray[k*32 +: 32] = $urandom;
            @(negedge clk);
            chk("w1_gnt", 32'(gnt1), 32'(s_req));
            chk("w32_gnt", 32'(gnt32), 32'(s_req));
            q_w1.push_back('{k, g2b(32'(s1_gray[k]), 1)});
            q_w32.push_back('{k, g2b(s32_gray[k*32 +: 32], 32)});
            @(posedge clk); #1;
        end
        s_req = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        chk("q_main_left", 32'(q_main.size()), 32'h0);
        chk("q_w1_left", 32'(q_w1.size()), 32'h0);
        chk("q_w32_left", 32'(q_w32.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray2bin_arb.md
Name: gray2bin_arb

Overview:
Shares one registered Gray-to-binary conversion pipeline among NREQ requesters. It selects one pending requester per cycle by round-robin, loads that requester's Gray word into a two-stage pipeline, and returns the binary result tagged with the requester index. A valid/ready handshake on the result side lets the downstream consumer stall the pipeline. It sits between the Gray-coded pointer/counter producers (CDC FIFO pointers, position encoders) and the logic that needs binary values.

Parameters:
DWID, 16, data width of the Gray input and binary output words
NREQ, 4, number of requesters (2..16)
IDW, 2, width of the requester tag; must equal ceil(log2(NREQ)), minimum 1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req  in  NREQ  request per requester; held high until granted
i_gray  in  NREQ*DWID  Gray words; requester k at bits [k*DWID +: DWID], stable while i_req[k] is high
o_gnt  out  NREQ  one-hot grant; word captured on the cycle o_gnt[k] is high
o_vld  out  1  result valid
o_id  out  IDW  requester index of the current result
o_bin  out  DWID  binary result
i_rdy  in  1  downstream accepts the result when o_vld and i_rdy are both high

Behaviour:
- Conversion: o_bin[j] = XOR of gray[DWID-1:j]; the MSB passes through unchanged. Purely combinational between stage 1 and stage 2; no width growth.
- Pipeline state:
  - Stage 1 registers: s1_vld, s1_id, s1_gray.
  - Stage 2 is the output registers: o_vld, o_id, o_bin.
- Flow control:
  - adv2 = !o_vld || i_rdy. When adv2=1, stage 2 loads from stage 1; o_vld takes s1_vld.
  - adv1 = !s1_vld || adv2. When adv1=1, stage 1 loads the granted word, or s1_vld=0 if there is no grant.
  - With adv2=0, o_vld, o_id and o_bin hold their values exactly.
- Grant:
  - o_gnt is combinational and is all-zero when rst=1, adv1=0, or i_req=0. Otherwise exactly one bit is set.
  - At most one grant per cycle. A requester must drop i_req the cycle after its grant, or it re-competes.
- Arbitration:
  - Round-robin pointer ptr (IDW bits). Search starts at ptr and wraps modulo NREQ. The first requesting index wins.
  - On a grant to index k, ptr <= (k+1) mod NREQ; the wrap from NREQ-1 goes to 0. With no grant, ptr holds.
- Latency: with no stall, a grant in cycle T gives o_vld=1 in cycle T+2 carrying that word. Full throughput is one result per cycle.
- Stalls: back-to-back stalls lose no data and duplicate none. Stage 1 holds while stage 2 is stalled. Grants resume in the same cycle i_rdy rises.
- Reset (synchronous), applied mid-operation included:
  - Next edge: o_vld=0, o_id=0, o_bin=0, s1_vld=0, s1_id=0, s1_gray=0, ptr=0.
  - In-flight words are discarded and no grant is issued while rst=1. The first cycle after rst deasserts may grant.
- Simultaneous events: a stage-2 handshake and a new grant in the same cycle are both honoured, so the pipeline stays full.

Optional Feature:
GRAY2BIN_ARB_FIXPRI_EN
- Defined: fixed priority, lowest index wins; ptr is not implemented.
- Undefined (default): round-robin as specified above.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Single requester 0, i_gray=0x8000, i_rdy=1 -> o_gnt=0001 in cycle T; cycle T+2 has o_vld=1, o_id=0, o_bin=0xFFFF. Repeat with 0x0003 -> 0x0002 and 0xC000 -> 0x8000.
- All four requesting continuously with distinct words, i_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles; o_id sequence 0,1,2,3,0 starting two cycles after the first grant. Under GRAY2BIN_ARB_FIXPRI_EN -> grant stays at 0.
- Requesters 1 and 3 only, after ptr=2 -> grant 3 first, then 1 (wrap), then 3.
- Pipeline full, i_rdy=0 for 5 cycles -> o_gnt=0 after stage 1 fills; o_vld/o_id/o_bin stable throughout. After i_rdy=1, results appear in original grant order with no loss or duplication.
- rst pulsed for one cycle while both stages are valid -> next cycle o_vld=0, o_bin=0, o_id=0; no result for the discarded words ever appears; following grant goes to the lowest requesting index (ptr=0).
- Sweep DWID=1 and DWID=32 with random Gray inputs -> o_bin matches the reference XOR-prefix model for every accepted result.
